// File: rtl/uart_tb_pkg.sv
// ============================================================================
//  Module   : uart_tb_pkg
//  Purpose  : Shared types and constants for the UART TX stimulus generator:
//             pattern mode encoding, FSM state encoding, LFSR constants and
//             the Galois LFSR step function.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tb_pkg;

  // Data pattern selection, encoded to match the i_mode port values
  typedef enum logic [1:0] {
    MODE_LFSR  = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_FIXED = 2'd2,
    MODE_WALK1 = 2'd3
  } mode_e;

  // Generator sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_GAP     = 3'd5,
    ST_FINISH  = 3'd6
  } state_e;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One right-shifting Galois step: the bit shifted out selects the tap mask
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_exp_fifo.sv
// ============================================================================
//  Module   : uart_exp_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO holding the words sent
//             to the UART TX, for a scoreboard to pop. A push while full with
//             no simultaneous pop drops the word and sets a sticky overflow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_exp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_aresetn,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     c_DEPTH = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic              w_pop_ok;
  logic              w_push_ok;

  // A pop frees a slot in the same cycle, so push-while-full is accepted then
  assign w_pop_ok  = i_pop & (r_count != '0);
  assign w_push_ok = i_push & ((r_count != c_DEPTH) | w_pop_ok);

  // Storage array; contents need no reset because the count gates validity
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer, occupancy and sticky overflow tracking
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_full     = (r_count == c_DEPTH);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/uart_tx_stim_gen.sv
// ============================================================================
//  Module   : uart_tx_stim_gen
//  Purpose  : Stimulus generator for a UART TX: issues a programmable number
//             of frames (LFSR / incrementing / fixed / walking-one data) with
//             a programmable idle gap, reporting progress and completion.
//  Options  : UART_GEN_EXP_FIFO_EN - when defined, every sent word is also
//             logged into an expected-data FIFO for a scoreboard; otherwise
//             the o_exp_* outputs are tied low and i_exp_ready is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_stim_gen
  import uart_tb_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          CNT_W     = 16,
  parameter int          GAP_W     = 16,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED,
  parameter int          EXP_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_aresetn,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_fixed_data,
  input  logic [CNT_W-1:0]  i_frame_count,
  input  logic [GAP_W-1:0]  i_gap_cycles,
  input  logic              i_tx_done,
  output logic              o_tx_start,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_sent_count,
  input  logic              i_exp_ready,
  output logic              o_exp_valid,
  output logic [DATA_W-1:0] o_exp_data,
  output logic              o_exp_overflow
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [15:0]       c_SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [DATA_W-1:0] c_WALK_INIT = DATA_W'(1);

  state_e            r_state;
  mode_e             r_mode;
  logic [DATA_W-1:0] r_fixed;
  logic [CNT_W-1:0]  r_count;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [CNT_W-1:0]  r_sent;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_lfsr;
  logic [DATA_W-1:0] r_incr;
  logic [DATA_W-1:0] r_walk;
  logic [DATA_W-1:0] w_pattern;
  logic [CNT_W-1:0]  w_sent_next;

  assign w_sent_next = r_sent + 1'b1;

  // Current pattern value for the latched mode
  always_comb begin
    w_pattern = r_lfsr[DATA_W-1:0];
    case (r_mode)
      MODE_INCR:  w_pattern = r_incr;
      MODE_FIXED: w_pattern = r_fixed;
      MODE_WALK1: w_pattern = r_walk;
      default:    w_pattern = r_lfsr[DATA_W-1:0];
    endcase
  end

  // Run sequencing FSM with registered outputs and pattern state
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_LFSR;
      r_fixed    <= '0;
      r_count    <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_sent     <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_lfsr     <= c_SEED;
      r_incr     <= '0;
      r_walk     <= c_WALK_INIT;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_mode  <= mode_e'(i_mode);
            r_fixed <= i_fixed_data;
            r_count <= i_frame_count;
            r_gap   <= i_gap_cycles;
            r_sent  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_incr  <= '0;
            r_walk  <= c_WALK_INIT;
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (!i_enable) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (i_tx_done) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_pattern;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          // Pulse is visible this cycle; step the active pattern for next frame
          case (r_mode)
            MODE_LFSR:  r_lfsr <= lfsr_next(r_lfsr);
            MODE_INCR:  r_incr <= r_incr + 1'b1;
            MODE_WALK1: r_walk <= {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
            default:    r_lfsr <= r_lfsr;
          endcase
          r_state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!i_tx_done) r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (i_tx_done) begin
            r_sent <= w_sent_next;
            if ((r_count != '0) && (w_sent_next == r_count)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_FINISH;
            end else if (!i_enable) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else if (r_gap == '0) begin
              r_tx_start <= 1'b1;
              r_tx_data  <= w_pattern;
              r_state    <= ST_START;
            end else begin
              r_gap_cnt <= r_gap - 1'b1;
              r_state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (!i_enable) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_gap_cnt == '0) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_pattern;
            r_state    <= ST_START;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        ST_FINISH: begin
          if (!i_enable) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_sent_count = r_sent;

`ifdef UART_GEN_EXP_FIFO_EN
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [$clog2(EXP_DEPTH):0] w_fifo_count;
  logic                       w_unused_fifo;

  uart_exp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (EXP_DEPTH)
  ) u_exp_fifo (
    .i_clk      (i_clk),
    .i_aresetn  (i_aresetn),
    .i_push     (r_tx_start),
    .i_data     (r_tx_data),
    .i_pop      (i_exp_ready),
    .o_data     (o_exp_data),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count),
    .o_overflow (o_exp_overflow)
  );

  assign o_exp_valid   = ~w_fifo_empty;
  assign w_unused_fifo = ^{w_fifo_full, w_fifo_count};
`else
  logic w_unused_exp;

  assign o_exp_valid    = 1'b0;
  assign o_exp_data     = '0;
  assign o_exp_overflow = 1'b0;
  assign w_unused_exp   = i_exp_ready ^ (EXP_DEPTH > 1);
`endif

endmodule

`default_nettype wire
